// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: input sync + glitch filter, 11-bit frame deserialiser, FWFT byte FIFO.
// Optional build macro PS2_BREAK_DECODE_EN folds F0 break prefixes into a per-entry rd_brk flag.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_ps2,
  input  logic                          data_ps2,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic [7:0]                    rd_data,
  output logic                          rd_brk,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_BREAK_DECODE_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---- stage p0: synchronisers and clock glitch filter ----
  logic [SYNC_STAGES-1:0] clk_sync_p0, dat_sync_p0;
  logic                   clk_filt_p0, clk_filt_d_p0;
  logic [FLT_W-1:0]       flt_cnt_p0;
  logic                   fall_p0, data_bit_p0;

  // Lines idle high, so the synchronisers come out of reset at 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0   <= '1;
      dat_sync_p0   <= '1;
      clk_filt_p0   <= 1'b1;
      clk_filt_d_p0 <= 1'b1;
      flt_cnt_p0    <= '0;
    end else begin
      clk_sync_p0   <= {clk_sync_p0[SYNC_STAGES-2:0], clk_ps2};
      dat_sync_p0   <= {dat_sync_p0[SYNC_STAGES-2:0], data_ps2};
      clk_filt_d_p0 <= clk_filt_p0;
      if (clk_sync_p0[SYNC_STAGES-1] == clk_filt_p0) begin
        flt_cnt_p0 <= '0;
      end else if (flt_cnt_p0 == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt_p0 <= ~clk_filt_p0;
        flt_cnt_p0  <= '0;
      end else begin
        flt_cnt_p0 <= flt_cnt_p0 + 1'b1;
      end
    end
  end

  assign fall_p0     = clk_filt_d_p0 & ~clk_filt_p0;
  assign data_bit_p0 = dat_sync_p0[SYNC_STAGES-1];

  // ---- frame FSM and deserialiser ----
  state_t           state, state_nxt;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [WD_W-1:0]  wd_cnt;
  logic             timeout, frame_good, frame_bad;

  assign timeout = (state != S_IDLE) && !fall_p0 && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else if (fall_p0) begin
      case (state)
        S_IDLE:   if (!data_bit_p0) state_nxt = S_DATA;
        S_DATA:   if (bitcnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Good frame: stop bit high and data+parity carry odd weight.
  always_comb begin
    frame_good = 1'b0;
    frame_bad  = timeout;
    if (fall_p0 && state == S_STOP) begin
      if (data_bit_p0 && (^{shreg, par_bit})) frame_good = 1'b1;
      else                                    frame_bad  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      wd_cnt <= '0;
    end else begin
      if (state == S_IDLE || timeout)       bitcnt <= '0;
      else if (fall_p0 && state == S_DATA)  bitcnt <= bitcnt + 1'b1;
      if (state == S_IDLE || fall_p0)       wd_cnt <= '0;
      else if (!timeout)                    wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fall_p0 && state == S_DATA)   shreg   <= {data_bit_p0, shreg[7:1]};
    if (fall_p0 && state == S_PARITY) par_bit <= data_bit_p0;
  end

  // ---- stage p1: registered push request and error pulse ----
  logic       vld_p1;
  logic [7:0] byte_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p1    <= frame_good;
      frame_err <= frame_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (frame_good) byte_p1 <= shreg;
  end

  logic               wr_en;
  logic [ENTRY_W-1:0] wr_entry;

`ifdef PS2_BREAK_DECODE_EN
  logic brk_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         brk_pending <= 1'b0;
    else if (vld_p1)    brk_pending <= (byte_p1 == 8'hF0);
    else if (frame_err) brk_pending <= 1'b0;
  end

  assign wr_en    = vld_p1 && (byte_p1 != 8'hF0);
  assign wr_entry = {brk_pending, byte_p1};
`else
  assign wr_en    = vld_p1;
  assign wr_entry = byte_p1;
`endif

  // ---- stage p2: FWFT circular buffer ----
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, do_push, do_pop, drop;
  logic [ENTRY_W-1:0] head;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = rd_en && (count != '0);
  assign do_push = wr_en && (!full || do_pop);
  assign drop    = wr_en && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Head is masked while empty so the outputs read 0 rather than stale storage.
  assign head     = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? head[7:0] : 8'h00;
`ifdef PS2_BREAK_DECODE_EN
  assign rd_brk   = rd_valid ? head[8] : 1'b0;
`else
  assign rd_brk   = 1'b0;
`endif

endmodule
